// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with first-word fall-through receive FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       overrun,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic rx_meta, rxs, rxs_prev;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic stop_tick, push_req, push, pop, fifo_full, overrun_set, frame_set;

    // Synchronizer and edge-history flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign fifo_full   = (count == DEPTH);
    assign pop         = rd_en && (count != '0);
    assign stop_tick   = (state == STOP) && (cnt == FULL_M1);
    assign push_req    = stop_tick && rxs;
    assign push        = push_req && (!fifo_full || pop);
    assign overrun_set = push_req && fifo_full && !pop;
    assign frame_set   = stop_tick && !rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving on the stop sample gives half a bit of slack before the next start edge.
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // When full, a same-cycle pop frees the slot at wr_ptr (== rd_ptr) being overwritten.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_set | (overrun & ~clr_err);
            frame_err <= frame_set | (frame_err & ~clr_err);
        end
    end

    assign rx_valid = (count != '0);
    assign rx_full  = fifo_full;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_full   (rx_full),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start, data and stop level; returns at the negedge just before the stop sample edge.
    task automatic send_head(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_tail(input int n);
        repeat (n) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b, 1'b1);
        send_tail(6);
    endtask

    task automatic pop_one;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_valid", {7'd0, rx_valid}, 8'd0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_full", {7'd0, rx_full}, 8'd0);
        check("reset_overrun", {7'd0, overrun}, 8'd0);
        check("reset_frame_err", {7'd0, frame_err}, 8'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single byte, exact push latency, pop to empty
        send_head(8'hA5, 1'b1);
        check("t1_valid_before_stop", {7'd0, rx_valid}, 8'd0);
        @(negedge clk);
        check("t1_valid_after_stop", {7'd0, rx_valid}, 8'd1);
        check("t1_data", rx_data, 8'hA5);
        send_tail(5);
        pop_one();
        check("t1_valid_after_pop", {7'd0, rx_valid}, 8'd0);
        check("t1_data_after_pop", rx_data, 8'h00);

        // 2: five back-to-back bytes into a depth-4 FIFO
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        check("t2_full_after_4", {7'd0, rx_full}, 8'd1);
        check("t2_no_overrun_4", {7'd0, overrun}, 8'd0);
        send_byte(8'h05);
        check("t2_overrun_after_5", {7'd0, overrun}, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_pop_%0d", i), rx_data, 8'(i));
            pop_one();
        end
        check("t2_empty_valid", {7'd0, rx_valid}, 8'd0);
        check("t2_empty_data", rx_data, 8'h00);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t2_overrun_cleared", {7'd0, overrun}, 8'd0);

        // 3: short glitch is rejected as a false start
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_glitch_valid", {7'd0, rx_valid}, 8'd0);
        check("t3_glitch_frame_err", {7'd0, frame_err}, 8'd0);
        send_byte(8'h3C);
        check("t3_valid", {7'd0, rx_valid}, 8'd1);
        check("t3_data", rx_data, 8'h3C);
        pop_one();

        // 4: framing error discards the byte and stays sticky
        repeat (4) @(negedge clk);
        send_head(8'h55, 1'b0);
        @(negedge clk);
        check("t4_frame_err_set", {7'd0, frame_err}, 8'd1);
        check("t4_nothing_pushed", {7'd0, rx_valid}, 8'd0);
        send_tail(5);
        repeat (8) @(negedge clk);
        send_byte(8'h66);
        check("t4_valid_66", {7'd0, rx_valid}, 8'd1);
        check("t4_data_66", rx_data, 8'h66);
        check("t4_frame_err_sticky", {7'd0, frame_err}, 8'd1);
        pop_one();

        // 5: pop on the exact stop-sample cycle while full
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("t5_full", {7'd0, rx_full}, 8'd1);
        send_head(8'h55, 1'b1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t5_no_overrun", {7'd0, overrun}, 8'd0);
        check("t5_still_full", {7'd0, rx_full}, 8'd1);
        check("t5_head_second", rx_data, 8'h22);
        send_tail(5);
        pop_one();
        check("t5_head_33", rx_data, 8'h33);
        pop_one();
        check("t5_head_44", rx_data, 8'h44);
        pop_one();
        check("t5_head_55", rx_data, 8'h55);
        check("t5_not_full", {7'd0, rx_full}, 8'd0);

        // 6: reset mid-frame (data bit 3 of 0xF0) with a byte and frame_err pending
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        check("t6_rst_valid", {7'd0, rx_valid}, 8'd0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_full", {7'd0, rx_full}, 8'd0);
        check("t6_rst_overrun", {7'd0, overrun}, 8'd0);
        check("t6_rst_frame_err", {7'd0, frame_err}, 8'd0);
        repeat (40) @(negedge clk);
        check("t6_idle_valid", {7'd0, rx_valid}, 8'd0);
        send_byte(8'h81);
        check("t6_valid_81", {7'd0, rx_valid}, 8'd1);
        check("t6_data_81", rx_data, 8'h81);
        pop_one();
        check("t6_one_byte_only", {7'd0, rx_valid}, 8'd0);
        check("t6_frame_err_clean", {7'd0, frame_err}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
